// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, legality helpers and status type for the parametrised FIFO
//
// Purpose: common definitions imported by fifo_mem and sync_fifo_param.
//   ptr_w()        : pointer/count width, $clog2(depth)+1 (extra wrap bit)
//   is_pow2()      : depth legality test used by the top-level elaboration checks
//   fifo_status_t  : decoded occupancy flags {full, empty, af, ae}
package fifo_pkg;

  localparam int MIN_DEPTH  = 2;
  localparam int MIN_DATA_W = 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= MIN_DEPTH) && ((v & (v - 1)) == 0);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic af;
    logic ae;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port storage with one sync write port and one registered read port
//
// Purpose: DATA_W x DEPTH array for sync_fifo_param.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (read register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; loads rdata_o from raddr_i at the edge
//   raddr_i  in   read address
//   rdata_o  out  registered read data, holds when re_i=0
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  // Storage is intentionally not reset: contents are don't-care until written.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: when full with a simultaneous read/write both addresses
  // match and the old (oldest) word is the one that must be returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with count, thresholds and flush
//
// Purpose: buffers words between a producer and a consumer in one clock domain.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   flush         in   synchronous clear of contents (wr/rd ignored that cycle)
//   wr_en/wr_data in   write request and data
//   rd_en         in   read request
//   rd_data       out  registered read data, holds when rd_valid=0
//   rd_valid      out  rd_data carries a word popped at the previous edge
//   full/empty    out  count == DEPTH / count == 0
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   count         out  current occupancy
//   overflow      out  sticky, write rejected (FIFO_ERR_FLAGS_EN only)
//   underflow     out  sticky, read on empty (FIFO_ERR_FLAGS_EN only)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ptr_w(DEPTH)-1:0]    count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int CW = ptr_w(DEPTH);
  localparam int AW = CW - 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (DATA_W < MIN_DATA_W) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be >= 1");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_acc, rd_acc;
  fifo_status_t  status;

  // Flags come straight from the count register, so they only move on
  // accepted transfers and never react to rejected requests.
  always_comb begin
    status       = '0;
    status.full  = (count_q == CW'(DEPTH));
    status.empty = (count_q == '0);
    status.af    = (count_q >= CW'(AF_THRESH));
    status.ae    = (count_q <= CW'(AE_THRESH));
  end

  // A write into a full FIFO is allowed only when a read frees a slot in the
  // same cycle; a read on empty never bypasses the incoming write.
  always_comb begin
    rd_acc = rd_en & ~status.empty & ~flush;
    wr_acc = wr_en & (~status.full | rd_acc) & ~flush;
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d     = wptr_q + CW'(wr_acc);
      rptr_d     = rptr_q + CW'(rd_acc);
      count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
      rd_valid_d = rd_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.af;
  assign almost_empty = status.ae;
  assign count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Requests swallowed by a flush are not treated as errors.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & ~wr_acc & ~flush);
    underflow_d = underflow_q | (rd_en & status.empty & ~flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param against a queue-based model
module tb_sync_fifo_param;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AF_THRESH = 14;
  localparam int AE_THRESH = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full, empty, almost_full, almost_empty;
  logic [CW-1:0]     count;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue; popped words go to the scoreboard.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] scb_q[$];
  bit                exp_valid = 1'b0;
  bit                exp_ovf = 1'b0;
  bit                exp_unf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else if (flush) begin
      model_q.delete();
      exp_valid = 1'b0;
    end else begin
      bit ra, wa;
      ra = rd_en && (model_q.size() > 0);
      wa = wr_en && ((model_q.size() < DEPTH) || ra);
      if (wr_en && !wa) exp_ovf = 1'b1;
      if (rd_en && model_q.size() == 0) exp_unf = 1'b1;
      if (ra) scb_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(wr_data);
      exp_valid = ra;
    end
  end

  // Monitor: compares every observable output on the falling edge.
  logic [DATA_W-1:0] last_data = '0;

  always @(negedge clk) begin
    int n;
    n = model_q.size();
    if (rst) last_data = '0;
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (scb_q.size() == 0) begin
        chk("scoreboard_underrun", 32'(scb_q.size()), 32'd1);
      end else begin
        last_data = scb_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(last_data));
      end
    end else begin
      chk("rd_data_hold", 32'(rd_data), 32'(last_data));
    end
    chk("count", 32'(count), n);
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF_THRESH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE_THRESH));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
`endif
  end

  task automatic cyc(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit f);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

    // Fill to full, one rejected write, then full with simultaneous wr/rd.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DATA_W'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

    // Empty with wr+rd: write only; then drain and read on empty.
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Interleaved traffic across many pointer wraps, then rare flushes.
    for (int i = 0; i < 120; i++)
      cyc(($urandom % 4) != 0, DATA_W'($urandom), ($urandom % 2) == 1, 1'b0);
    for (int i = 0; i < 300; i++)
      cyc(($urandom % 2) == 1, DATA_W'($urandom), ($urandom % 2) == 1, ($urandom % 32) == 0);
    repeat (DEPTH + 2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Count 9 then flush with a concurrent write.
    for (int i = 0; i < 9; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 8; i++) cyc(1'b1, DATA_W'($urandom), (i % 3) == 2, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_full", 32'(full), 32'd0);
    chk("async_rst_ae", 32'(almost_empty), 32'd1);
    chk("async_rst_af", 32'(almost_full), 32'd0);
    chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rst_rd_data", 32'(rd_data), 32'd0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, DATA_W'(8'h50 + i), 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", 32'(scb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
